// File: rtl/beta_pkg.sv
// Shared constants, types and helpers for the beta core register file.
package beta_pkg;

    localparam int XLEN        = 32;
    localparam int RF_AW       = 5;
    localparam int RV32I_NREGS = 32;
    localparam int RV32E_NREGS = 16;

    typedef logic [RF_AW-1:0] rf_addr_t;

    // In RV32E mode the upper half of the address space does not exist.
    function automatic logic rf_addr_legal(input rf_addr_t addr, input int nregs);
        return (nregs == RV32I_NREGS) || !addr[RF_AW-1];
    endfunction

endpackage

// File: rtl/beta_regfile_mp_if.sv
// Bundle of read, write and reserve signals between decode/writeback and the register file.
interface beta_regfile_mp_if
    import beta_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 1
);
    rf_addr_t [NRD-1:0]            rs_addr_i;
    logic     [NRD-1:0][XLEN-1:0]  rs_data_o;
    logic     [NRD-1:0]            rs_busy_o;
    logic     [NWR-1:0]            wr_en_i;
    rf_addr_t [NWR-1:0]            wr_addr_i;
    logic     [NWR-1:0][XLEN-1:0]  wr_data_i;
    logic                          rsv_en_i;
    rf_addr_t                      rsv_addr_i;
    logic     [NREGS-1:0]          busy_o;
    logic                          illegal_o;

    modport master (
        output rs_addr_i, wr_en_i, wr_addr_i, wr_data_i, rsv_en_i, rsv_addr_i,
        input  rs_data_o, rs_busy_o, busy_o, illegal_o
    );

    modport slave (
        input  rs_addr_i, wr_en_i, wr_addr_i, wr_data_i, rsv_en_i, rsv_addr_i,
        output rs_data_o, rs_busy_o, busy_o, illegal_o
    );
endinterface

// File: rtl/beta_rf_scoreboard.sv
// Per-register busy scoreboard: writes clear, reservations set, set beats clear.
module beta_rf_scoreboard
    import beta_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int NWR   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic     [NWR-1:0]    clr_en_i,
    input  rf_addr_t [NWR-1:0]    clr_addr_i,
    input  logic                  set_en_i,
    input  rf_addr_t              set_addr_i,
    output logic     [NREGS-1:0]  busy_o
);
    localparam int IW = (NREGS == RV32E_NREGS) ? 4 : 5;

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Clears first, then the reservation, so a same-cycle new producer keeps the bit set.
    always_comb begin
        busy_d = busy_q;
        for (int p = 0; p < NWR; p++) begin
            if (clr_en_i[p]) begin
                busy_d[clr_addr_i[p][IW-1:0]] = 1'b0;
            end
        end
        if (set_en_i) begin
            busy_d[set_addr_i[IW-1:0]] = 1'b1;
        end
    end

    // Busy vector register; reset drops every outstanding reservation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/beta_regfile_mp.sv
// Multi-port integer register file with optional RV32E mode, write bypass and busy scoreboard.
module beta_regfile_mp
    import beta_pkg::*;
#(
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    beta_regfile_mp_if.slave  rf
);
    localparam int IW = (NREGS == RV32E_NREGS) ? 4 : 5;

    if (!(NREGS == RV32I_NREGS || NREGS == RV32E_NREGS) || NRD < 1 || NRD > 4
        || NWR < 1 || NWR > 2) begin : g_bad_params
        $fatal(1, "beta_regfile_mp: unsupported NREGS/NRD/NWR combination");
    end

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NWR-1:0]   wr_ok;
    logic             rsv_ok;
    logic [NREGS-1:0] busy_vec;
    logic             illegal_q;
    logic             illegal_d;
    logic             any_illegal;

    // Qualified requests: enabled, legal, not x0, and not in a reset cycle.
    always_comb begin
        wr_ok = '0;
        for (int p = 0; p < NWR; p++) begin
            wr_ok[p] = !rst_i && rf.wr_en_i[p] && rf_addr_legal(rf.wr_addr_i[p], NREGS)
                       && (rf.wr_addr_i[p] != '0);
        end
        rsv_ok = !rst_i && rf.rsv_en_i && rf_addr_legal(rf.rsv_addr_i, NREGS)
                 && (rf.rsv_addr_i != '0);
    end

    // Storage next state; later ports overwrite earlier ones on a collision.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        for (int p = 0; p < NWR; p++) begin
            if (wr_ok[p]) begin
                regs_d[rf.wr_addr_i[p][IW-1:0]] = rf.wr_data_i[p];
            end
        end
    end

    // Register storage with synchronous clear.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NREGS; i++) begin
            if (rst_i) begin
                regs_q[i] <= '0;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    beta_rf_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_en_i   (wr_ok),
        .clr_addr_i (rf.wr_addr_i),
        .set_en_i   (rsv_ok),
        .set_addr_i (rf.rsv_addr_i),
        .busy_o     (busy_vec)
    );

    assign rf.busy_o = busy_vec;

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [XLEN-1:0] rd_data;
        logic            rd_busy;
        rf_addr_t        ra;

        assign ra = rf.rs_addr_i[gi];

        // Read mux: x0 and nonexistent registers read as zero and idle; bypass overrides storage.
        always_comb begin
            rd_data = '0;
            rd_busy = 1'b0;
            if (rf_addr_legal(ra, NREGS) && (ra != '0)) begin
                rd_data = regs_q[ra[IW-1:0]];
                rd_busy = busy_vec[ra[IW-1:0]];
            end
            if (BYPASS != 0) begin
                for (int p = 0; p < NWR; p++) begin
                    if (wr_ok[p] && (rf.wr_addr_i[p] == ra)) begin
                        rd_data = rf.wr_data_i[p];
                        rd_busy = 1'b0;
                    end
                end
            end
        end

        assign rf.rs_data_o[gi] = rd_data;
        assign rf.rs_busy_o[gi] = rd_busy;
    end

    // Detect any access to a nonexistent register this cycle.
    always_comb begin
        any_illegal = 1'b0;
        for (int r = 0; r < NRD; r++) begin
            if (!rf_addr_legal(rf.rs_addr_i[r], NREGS)) begin
                any_illegal = 1'b1;
            end
        end
        for (int p = 0; p < NWR; p++) begin
            if (rf.wr_en_i[p] && !rf_addr_legal(rf.wr_addr_i[p], NREGS)) begin
                any_illegal = 1'b1;
            end
        end
        if (rf.rsv_en_i && !rf_addr_legal(rf.rsv_addr_i, NREGS)) begin
            any_illegal = 1'b1;
        end
        illegal_d = illegal_q | any_illegal;
    end

    // Sticky illegal-access flag, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign rf.illegal_o = illegal_q;

endmodule

// File: tb/tb_beta_regfile_mp.sv
// Bench: three register-file configurations driven by one stimulus stream, checked against a model.
module tb_beta_regfile_mp;
    import beta_pkg::*;

    logic clk = 1'b0;
    logic s_rst = 1'b0;

    always #5 clk = ~clk;

    // Shared stimulus; single-write-port instances see only port 0.
    logic [1:0]  s_wen = '0;
    logic [4:0]  s_waddr [2];
    logic [31:0] s_wdata [2];
    logic        s_rsv = 1'b0;
    logic [4:0]  s_rsv_addr = '0;
    logic [4:0]  s_ra [2];

    beta_regfile_mp_if #(.NREGS(32), .NRD(2), .NWR(2)) if_a ();
    beta_regfile_mp_if #(.NREGS(32), .NRD(2), .NWR(1)) if_b ();
    beta_regfile_mp_if #(.NREGS(16), .NRD(2), .NWR(1)) if_c ();

    beta_regfile_mp #(.NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) dut_a (
        .clk_i (clk), .rst_i (s_rst), .rf (if_a.slave));
    beta_regfile_mp #(.NREGS(32), .NRD(2), .NWR(1), .BYPASS(0)) dut_b (
        .clk_i (clk), .rst_i (s_rst), .rf (if_b.slave));
    beta_regfile_mp #(.NREGS(16), .NRD(2), .NWR(1), .BYPASS(1)) dut_c (
        .clk_i (clk), .rst_i (s_rst), .rf (if_c.slave));

    assign if_a.rs_addr_i[0] = s_ra[0];
    assign if_a.rs_addr_i[1] = s_ra[1];
    assign if_a.wr_en_i      = s_wen;
    assign if_a.wr_addr_i[0] = s_waddr[0];
    assign if_a.wr_addr_i[1] = s_waddr[1];
    assign if_a.wr_data_i[0] = s_wdata[0];
    assign if_a.wr_data_i[1] = s_wdata[1];
    assign if_a.rsv_en_i     = s_rsv;
    assign if_a.rsv_addr_i   = s_rsv_addr;

    assign if_b.rs_addr_i[0] = s_ra[0];
    assign if_b.rs_addr_i[1] = s_ra[1];
    assign if_b.wr_en_i      = s_wen[0];
    assign if_b.wr_addr_i[0] = s_waddr[0];
    assign if_b.wr_data_i[0] = s_wdata[0];
    assign if_b.rsv_en_i     = s_rsv;
    assign if_b.rsv_addr_i   = s_rsv_addr;

    assign if_c.rs_addr_i[0] = s_ra[0];
    assign if_c.rs_addr_i[1] = s_ra[1];
    assign if_c.wr_en_i      = s_wen[0];
    assign if_c.wr_addr_i[0] = s_waddr[0];
    assign if_c.wr_data_i[0] = s_wdata[0];
    assign if_c.rsv_en_i     = s_rsv;
    assign if_c.rsv_addr_i   = s_rsv_addr;

    // DUT outputs gathered per instance.
    logic [31:0] act_data [3][2];
    logic        act_rbusy [3][2];
    logic [31:0] act_busyv [3];
    logic        act_ill [3];

    assign act_data[0][0] = if_a.rs_data_o[0];
    assign act_data[0][1] = if_a.rs_data_o[1];
    assign act_data[1][0] = if_b.rs_data_o[0];
    assign act_data[1][1] = if_b.rs_data_o[1];
    assign act_data[2][0] = if_c.rs_data_o[0];
    assign act_data[2][1] = if_c.rs_data_o[1];
    assign act_rbusy[0][0] = if_a.rs_busy_o[0];
    assign act_rbusy[0][1] = if_a.rs_busy_o[1];
    assign act_rbusy[1][0] = if_b.rs_busy_o[0];
    assign act_rbusy[1][1] = if_b.rs_busy_o[1];
    assign act_rbusy[2][0] = if_c.rs_busy_o[0];
    assign act_rbusy[2][1] = if_c.rs_busy_o[1];
    assign act_busyv[0] = if_a.busy_o;
    assign act_busyv[1] = if_b.busy_o;
    assign act_busyv[2] = {16'h0, if_c.busy_o};
    assign act_ill[0] = if_a.illegal_o;
    assign act_ill[1] = if_b.illegal_o;
    assign act_ill[2] = if_c.illegal_o;

    // Model of architectural state per instance.
    int          cfg_nwr   [3] = '{2, 1, 1};
    int          cfg_nregs [3] = '{32, 32, 16};
    int          cfg_byp   [3] = '{1, 0, 1};
    logic [31:0] m_mem  [3][32];
    bit          m_busy [3][32];
    bit          m_ill  [3];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    function automatic bit m_legal(int k, logic [4:0] a);
        return (cfg_nregs[k] == 32) || (a < 5'd16);
    endfunction

    function automatic logic [31:0] exp_data(int k, logic [4:0] a);
        logic [31:0] v;
        if (!m_legal(k, a) || a == 5'd0) return 32'h0;
        v = m_mem[k][a];
        if (cfg_byp[k] != 0 && !s_rst) begin
            for (int p = 0; p < cfg_nwr[k]; p++) begin
                if (s_wen[p] && s_waddr[p] == a) v = s_wdata[p];
            end
        end
        return v;
    endfunction

    function automatic bit exp_rbusy(int k, logic [4:0] a);
        bit b;
        if (!m_legal(k, a) || a == 5'd0) return 1'b0;
        b = m_busy[k][a];
        if (cfg_byp[k] != 0 && !s_rst) begin
            for (int p = 0; p < cfg_nwr[k]; p++) begin
                if (s_wen[p] && s_waddr[p] == a) b = 1'b0;
            end
        end
        return b;
    endfunction

    function automatic logic [31:0] exp_busyv(int k);
        logic [31:0] v = '0;
        for (int i = 0; i < cfg_nregs[k]; i++) v[i] = m_busy[k][i];
        return v;
    endfunction

    // Apply one clock edge of architectural effects to the model.
    task automatic model_update();
        for (int k = 0; k < 3; k++) begin
            if (s_rst) begin
                for (int i = 0; i < 32; i++) begin
                    m_mem[k][i]  = 32'h0;
                    m_busy[k][i] = 1'b0;
                end
                m_ill[k] = 1'b0;
            end else begin
                for (int r = 0; r < 2; r++) begin
                    if (!m_legal(k, s_ra[r])) m_ill[k] = 1'b1;
                end
                for (int p = 0; p < cfg_nwr[k]; p++) begin
                    if (s_wen[p]) begin
                        if (!m_legal(k, s_waddr[p])) m_ill[k] = 1'b1;
                        else if (s_waddr[p] != 5'd0) begin
                            m_mem[k][s_waddr[p]]  = s_wdata[p];
                            m_busy[k][s_waddr[p]] = 1'b0;
                        end
                    end
                end
                if (s_rsv) begin
                    if (!m_legal(k, s_rsv_addr)) m_ill[k] = 1'b1;
                    else if (s_rsv_addr != 5'd0) m_busy[k][s_rsv_addr] = 1'b1;
                end
            end
        end
    endtask

    task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %h expected %h", name, k, act, exp);
        end
    endtask

    // Compare process: every output of every instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                for (int r = 0; r < 2; r++) begin
                    chk("rs_data", k, act_data[k][r], exp_data(k, s_ra[r]));
                    chk("rs_busy", k, {31'h0, act_rbusy[k][r]}, {31'h0, exp_rbusy(k, s_ra[r])});
                end
                chk("busy_o", k, act_busyv[k], exp_busyv(k));
                chk("illegal_o", k, {31'h0, act_ill[k]}, {31'h0, m_ill[k]});
            end
        end
    end

    // Drive one cycle of stimulus and settle just before the falling edge.
    task automatic cyc(input logic rst, input logic [1:0] wen,
                       input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic rsv, input logic [4:0] rsa,
                       input logic [4:0] ra0, input logic [4:0] ra1);
        s_rst = rst;
        s_wen = wen;
        s_waddr[0] = wa0;
        s_wdata[0] = wd0;
        s_waddr[1] = wa1;
        s_wdata[1] = wd1;
        s_rsv = rsv;
        s_rsv_addr = rsa;
        s_ra[0] = ra0;
        s_ra[1] = ra1;
        #3;
    endtask

    task automatic rd(input logic [4:0] ra0, input logic [4:0] ra1);
        cyc(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, ra0, ra1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Directed scenarios with hand-computed expectations, then mixed traffic.
    initial begin
        s_waddr[0] = '0; s_waddr[1] = '0;
        s_wdata[0] = '0; s_wdata[1] = '0;
        s_ra[0] = '0; s_ra[1] = '0;
        @(posedge clk);
        #1;
        cyc(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        chk_en = 1'b1;
        cyc(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        chk("lit_rst_busy", 0, act_busyv[0], 32'h0);
        chk("lit_rst_ill", 2, {31'h0, act_ill[2]}, 32'h0);
        tick();

        for (int a = 0; a < 16; a++) begin
            rd(5'(2 * a), 5'(2 * a + 1));
            chk("lit_rst_rd0", 0, act_data[0][0], 32'h0);
            chk("lit_rst_rd1", 0, act_data[0][1], 32'h0);
            tick();
        end
        rd(5'd0, 5'd0);
        chk("lit_e_read_ill", 2, {31'h0, act_ill[2]}, 32'h1);
        tick();
        cyc(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();

        cyc(1'b0, 2'b11, 5'd0, 32'hDEADBEEF, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0);
        chk("lit_x0_byp", 0, act_data[0][0], 32'h0);
        tick();
        rd(5'd0, 5'd0);
        chk("lit_x0_a", 0, act_data[0][0], 32'h0);
        chk("lit_x0_b", 1, act_data[1][0], 32'h0);
        tick();

        cyc(1'b0, 2'b01, 5'd5, 32'h12345678, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);
        chk("lit_x5_byp", 0, act_data[0][0], 32'h12345678);
        chk("lit_x5_nobyp", 1, act_data[1][0], 32'h0);
        tick();
        rd(5'd5, 5'd0);
        chk("lit_x5_next", 1, act_data[1][0], 32'h12345678);
        tick();

        cyc(1'b0, 2'b11, 5'd7, 32'h1, 5'd7, 32'h2, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        rd(5'd7, 5'd0);
        chk("lit_x7_collide", 0, act_data[0][0], 32'h2);
        chk("lit_x7_single", 1, act_data[1][0], 32'h1);
        tick();

        cyc(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0);
        chk("lit_rsv_same", 0, {31'h0, act_rbusy[0][0]}, 32'h0);
        tick();
        rd(5'd9, 5'd0);
        chk("lit_rsv_busyo", 0, act_busyv[0], 32'h200);
        chk("lit_rsv_rbusy", 0, {31'h0, act_rbusy[0][0]}, 32'h1);
        tick();
        cyc(1'b0, 2'b01, 5'd9, 32'hA5, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0);
        chk("lit_clr_byp", 0, {31'h0, act_rbusy[0][0]}, 32'h0);
        chk("lit_clr_data", 0, act_data[0][0], 32'hA5);
        chk("lit_clr_nobyp", 1, {31'h0, act_rbusy[1][0]}, 32'h1);
        tick();
        rd(5'd9, 5'd0);
        chk("lit_clr_busyo", 0, act_busyv[0], 32'h0);
        chk("lit_clr_val", 1, act_data[1][0], 32'hA5);
        tick();
        cyc(1'b0, 2'b01, 5'd9, 32'h5A, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd0);
        tick();
        rd(5'd9, 5'd0);
        chk("lit_rsvwr_busyo", 0, act_busyv[0], 32'h200);
        chk("lit_rsvwr_data", 0, act_data[0][0], 32'h5A);
        chk("lit_rsvwr_rbusy", 0, {31'h0, act_rbusy[0][0]}, 32'h1);
        tick();

        cyc(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        cyc(1'b0, 2'b01, 5'd20, 32'h55, 5'd0, 32'h0, 1'b0, 5'd0, 5'd20, 5'd0);
        chk("lit_e_rd_data", 2, act_data[2][0], 32'h0);
        chk("lit_e_rd_busy", 2, {31'h0, act_rbusy[2][0]}, 32'h0);
        chk("lit_e_ill_pre", 2, {31'h0, act_ill[2]}, 32'h0);
        tick();
        rd(5'd20, 5'd0);
        chk("lit_e_ill", 2, {31'h0, act_ill[2]}, 32'h1);
        chk("lit_e_rd20", 2, act_data[2][0], 32'h0);
        chk("lit_i_ill", 0, {31'h0, act_ill[0]}, 32'h0);
        tick();
        cyc(1'b0, 2'b01, 5'd15, 32'hF0F0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd15, 5'd0);
        chk("lit_e_x15_byp", 2, act_data[2][0], 32'hF0F0);
        tick();
        rd(5'd15, 5'd0);
        chk("lit_e_x15", 2, act_data[2][0], 32'hF0F0);
        chk("lit_e_sticky", 2, {31'h0, act_ill[2]}, 32'h1);
        tick();
        cyc(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        rd(5'd0, 5'd0);
        chk("lit_e_ill_rst", 2, {31'h0, act_ill[2]}, 32'h0);
        tick();

        cyc(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0);
        tick();
        cyc(1'b0, 2'b01, 5'd6, 32'h77, 5'd0, 32'h0, 1'b1, 5'd4, 5'd0, 5'd0);
        tick();
        rd(5'd6, 5'd3);
        chk("lit_pre_x6", 0, act_data[0][0], 32'h77);
        chk("lit_pre_busy", 0, act_busyv[0], 32'h18);
        tick();
        cyc(1'b1, 2'b01, 5'd6, 32'h99, 5'd0, 32'h0, 1'b0, 5'd0, 5'd6, 5'd3);
        tick();
        rd(5'd6, 5'd3);
        chk("lit_post_busy", 0, act_busyv[0], 32'h0);
        chk("lit_post_x6", 0, act_data[0][0], 32'h0);
        chk("lit_post_x6b", 1, act_data[1][0], 32'h0);
        chk("lit_post_ill", 2, {31'h0, act_ill[2]}, 32'h0);
        tick();

        for (int n = 0; n < 300; n++) begin
            cyc(($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)),
                5'($urandom_range(0, 31)), $urandom(),
                5'($urandom_range(0, 31)), $urandom(),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            tick();
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
